// File: rtl/updown_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : updown_counter_bank
// Purpose  : Bank of NUM_CH independent up/down counters, each ranging 0..MAX.
//            Every channel wraps modulo MAX+1 (WRAP=1) or saturates at 0/MAX
//            (WRAP=0). Per-edge priority is clear > load > enable. A registered
//            one-cycle event pulse flags a wrap or an attempted step past a
//            limit.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1                  clock, rising edge
//   reset       in   1                  asynchronous active-high reset
//   enable      in   NUM_CH             per-channel count enable
//   up          in   NUM_CH             1 = increment, 0 = decrement
//   clear       in   NUM_CH             synchronous clear to 0 (top priority)
//   load        in   NUM_CH             synchronous load of clamped load_value
//   load_value  in   NUM_CH*COUNT_BITS  channel i at [i*COUNT_BITS +: COUNT_BITS]
//   count       out  NUM_CH*COUNT_BITS  registered counter values, same packing
//   max_tick    out  NUM_CH             count[i] == MAX (combinational)
//   min_tick    out  NUM_CH             count[i] == 0   (combinational)
//   event_pulse out  NUM_CH             registered wrap / saturation-hit pulse
//   any_event   out  1                  OR of event_pulse
// ============================================================================
module updown_counter_bank #(
    parameter int NUM_CH     = 4,
    parameter int COUNT_BITS = 8,
    parameter int MAX        = 200,
    parameter int WRAP       = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CH-1:0]              enable,
    input  logic [NUM_CH-1:0]              up,
    input  logic [NUM_CH-1:0]              clear,
    input  logic [NUM_CH-1:0]              load,
    input  logic [NUM_CH*COUNT_BITS-1:0]   load_value,
    output logic [NUM_CH*COUNT_BITS-1:0]   count,
    output logic [NUM_CH-1:0]              max_tick,
    output logic [NUM_CH-1:0]              min_tick,
    output logic [NUM_CH-1:0]              event_pulse,
    output logic                           any_event
);

    localparam logic [COUNT_BITS-1:0] c_MAX  = COUNT_BITS'(MAX);
    localparam logic [COUNT_BITS-1:0] c_ZERO = '0;
    localparam logic [COUNT_BITS-1:0] c_ONE  = COUNT_BITS'(1);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [COUNT_BITS-1:0] r_cnt;
        logic                  r_evt;
        logic [COUNT_BITS-1:0] w_lv;
        logic [COUNT_BITS-1:0] w_nxt;
        logic                  w_evt;

        assign w_lv = load_value[gi*COUNT_BITS +: COUNT_BITS];

        // Limits are tested explicitly before stepping so that a MAX below
        // 2^COUNT_BITS-1 still wraps at MAX and nothing relies on natural
        // binary overflow.
        always_comb begin
            w_nxt = r_cnt;
            w_evt = 1'b0;
            if (clear[gi]) begin
                w_nxt = c_ZERO;
            end else if (load[gi]) begin
                w_nxt = (w_lv > c_MAX) ? c_MAX : w_lv;
            end else if (enable[gi]) begin
                if (up[gi]) begin
                    if (r_cnt == c_MAX) begin
                        w_evt = 1'b1;
                        w_nxt = (WRAP != 0) ? c_ZERO : c_MAX;
                    end else begin
                        w_nxt = r_cnt + c_ONE;
                    end
                end else begin
                    if (r_cnt == c_ZERO) begin
                        w_evt = 1'b1;
                        w_nxt = (WRAP != 0) ? c_MAX : c_ZERO;
                    end else begin
                        w_nxt = r_cnt - c_ONE;
                    end
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt <= c_ZERO;
                r_evt <= 1'b0;
            end else begin
                r_cnt <= w_nxt;
                r_evt <= w_evt;
            end
        end

        assign count[gi*COUNT_BITS +: COUNT_BITS] = r_cnt;
        assign event_pulse[gi]                    = r_evt;
        assign max_tick[gi]                       = (r_cnt == c_MAX);
        assign min_tick[gi]                       = (r_cnt == c_ZERO);
    end : g_ch

    assign any_event = |event_pulse;

endmodule : updown_counter_bank
`default_nettype wire
